fetch_pc_unit: RTL
==================

# fetch_pc_unit

Instruction-fetch stage of the 5-stage RISCVCPU pipeline. Owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register consumed by the decode stage. Handles load-use stalls from the hazard unit and branch/jump redirects resolved in EX, inserting NOP bubbles on flush. Traps misaligned redirect targets into a sticky fault state.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: bubble encoding (`addi x0,x0,0`).
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID register.
- redirect_valid  in  1  EX resolved a taken branch, JAL or JALR.
- redirect_target  in  32  EX-computed target address.
- imem_rdata  in  32  instruction word at imem_addr (combinational read).
- imem_addr  out  32  current PC, driven to instruction memory.
- if_id_valid  out  1  IF/ID register holds a real instruction.
- if_id_pc  out  32  PC of instruction in IF/ID.
- if_id_instruction  out  32  instruction in IF/ID (NOP_INSTR when invalid).
- if_id_pred_taken  out  1  IF predicted this instruction taken (0 when macro absent).
- flush  out  1  combinational; equals redirect_valid when in RUN, tells ID/EX to squash.
- fault  out  1  sticky misaligned-target indicator.
- fetch_count  out  32  instructions delivered to IF/ID since reset.

## Operation
- States: RUN, FAULT. Reset -> RUN.
- RUN, priority (highest first): redirect, stall, normal fetch.
  - redirect_valid with target[1:0]==0: PC <= redirect_target; IF/ID <= bubble (valid 0, instruction NOP_INSTR, pc 0). Overrides stall.
  - redirect_valid with target[1:0]!=0: PC unchanged; IF/ID <= bubble; fault <= 1; state -> FAULT.
  - stall (no redirect): PC, IF/ID, fetch_count all hold.
  - otherwise: IF/ID <= {1, PC, imem_rdata}; PC <= next PC; fetch_count += 1.
- Next PC = PC + 4 (32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000 silently).
- FAULT: PC holds, IF/ID held as bubble, flush held 0, inputs ignored; exit only by reset.
- fetch_count wraps modulo 2^32; bubbles never count.
- Reset values: PC = RESET_PC, if_id_valid 0, if_id_pc 0, if_id_instruction NOP_INSTR, if_id_pred_taken 0, fault 0, fetch_count 0, state RUN. flush = 0 during reset.

## Timing
- imem_addr = PC, combinational from the PC register; instruction captured into IF/ID at the same edge PC advances. Fetch-to-ID latency: 1 cycle.
- First fetch: cycle after reset deasserts, imem_addr = RESET_PC; if_id_valid rises at the following edge.
- Redirect: target appears on imem_addr one cycle after redirect_valid; its instruction reaches IF/ID two edges after. Two slots (IF/ID and ID/EX) squashed: 2-cycle taken-branch penalty.
- Stall and redirect same cycle: redirect wins, stall ignored.
- Reset mid-stall or mid-redirect: reset wins; all state to reset values at that edge.

## Configuration
- STATIC_BTFN_EN defined: IF predecodes imem_rdata; B-type with negative immediate, or JAL, is predicted taken: PC <= PC + imm (no redirect wait), if_id_pred_taken = 1. EX must only assert redirect_valid on mispredict (target = correct next PC). Misaligned predicted target is not followed (falls through PC+4, pred_taken 0).
- Undefined: no predecode, PC always PC+4 absent redirect, if_id_pred_taken tied 0.

## Test plan
- Reset release, imem sequential NOPs, 4 cycles -> imem_addr 0,4,8,C; if_id_pc 0,4,8; fetch_count 3; if_id_valid 1 from 2nd edge.
- Stall for 2 cycles at PC 0x8 -> imem_addr stays 0x8, IF/ID holds pc 0x4, fetch_count unchanged; resumes 0xC after release.
- redirect_valid with target 0x40 at PC 0x10 -> flush 1 that cycle; next imem_addr 0x40; if_id bubble (NOP_INSTR, valid 0); next if_id_pc 0x40.
- Stall and redirect to 0x20 same cycle -> PC 0x20 next cycle, bubble in IF/ID.
- Redirect target 0x22 -> fault 1 sticky, PC frozen, further redirects ignored; reset -> fault 0, PC = RESET_PC.
- STATIC_BTFN_EN: `beq x0,x0,-8` at 0x10 -> next imem_addr 0x08, if_id_pred_taken 1; without macro -> 0x14, pred_taken 0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, drives imem_addr and loads the IF/ID register.
// Optional static backward-taken/forward-not-taken prediction under `define STATIC_BTFN_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_pred_taken,
    output logic        flush,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_pred_q, id_pred_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic [31:0] seq_pc;
    logic [31:0] fetch_next;
    logic        fetch_pred;

    assign seq_pc = pc_q + 32'd4;

`ifdef STATIC_BTFN_EN
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic [31:0] pred_target;

    assign b_imm = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                    imem_rdata[11:8], 1'b0};
    assign j_imm = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                    imem_rdata[30:21], 1'b0};

    always_comb begin
        fetch_pred  = 1'b0;
        pred_target = seq_pc;
        if (imem_rdata[6:0] == 7'b1100011 && imem_rdata[31]) begin
            fetch_pred  = 1'b1;
            pred_target = pc_q + b_imm;
        end else if (imem_rdata[6:0] == 7'b1101111) begin
            fetch_pred  = 1'b1;
            pred_target = pc_q + j_imm;
        end
        // A misaligned predicted target is not followed; EX resolves it normally.
        if (fetch_pred && pred_target[1:0] != 2'b00) begin
            fetch_pred  = 1'b0;
            pred_target = seq_pc;
        end
        fetch_next = pred_target;
    end
`else
    assign fetch_pred = 1'b0;
    assign fetch_next = seq_pc;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_pred_d  = id_pred_q;
        fault_d    = fault_q;
        count_d    = count_q;
        if (state_q == StRun) begin
            if (redirect_valid) begin
                valid_d    = 1'b0;
                id_pc_d    = 32'h0;
                id_instr_d = NOP_INSTR;
                id_pred_d  = 1'b0;
                if (redirect_target[1:0] == 2'b00) begin
                    pc_d = redirect_target;
                end else begin
                    fault_d = 1'b1;
                    state_d = StFault;
                end
            end else if (!stall) begin
                valid_d    = 1'b1;
                id_pc_d    = pc_q;
                id_instr_d = imem_rdata;
                id_pred_d  = fetch_pred;
                pc_d       = fetch_next;
                count_d    = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            id_pc_q    <= 32'h0;
            id_instr_q <= NOP_INSTR;
            id_pred_q  <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_pred_q  <= id_pred_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr         = pc_q;
    assign if_id_valid       = valid_q;
    assign if_id_pc          = id_pc_q;
    assign if_id_instruction = id_instr_q;
    assign if_id_pred_taken  = id_pred_q;
    assign fault             = fault_q;
    assign fetch_count       = count_q;
    assign flush             = (state_q == StRun) && redirect_valid && !reset;

endmodule
